pic_fetch_seq: RTL and testbench
================================

// Module: pic_fetch_seq
// PURPOSE
//  Instruction fetch/flow-control sequencer for the 12-bit-ISA PIC core.
//  - Latches the program-ROM word addressed by the PC register into the IR.
//  - Decodes GOTO/CALL/RETLW/skip/PCL-write and drives the PC register's
//    load/push/pop strobes, target address and literal.
//  - Squashes the prefetched word after any change of flow, giving 2-cycle branches.
//  - Tracks hardware-stack depth; flags overflow and underflow.
// PARAMETERS
//  AW          9      program address width (PC/ROM address)
//  IW          12     instruction width
//  STACK_DEPTH 2      hardware stack levels in the PC register
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous, active-high
//  pc_addr     in   AW  current PC (PC register addr_out); also the ROM address
//  rom_data    in   IW  ROM word at pc_addr (combinational read)
//  skip_cond   in   1   ALU: skip test true for the executing instruction
//  pcl_wr      in   1   datapath is writing PCL this cycle (PC write_en)
//  ir          out  IW  executing instruction; 12'h000 (NOP) when squashed
//  ir_valid    out  1   ir holds a real fetched instruction
//  pc_load     out  1   PC load strobe; target on pc_target
//  pc_push     out  1   PC push strobe (CALL); literal on pc_lit
//  pc_pop      out  1   PC pop strobe (RETLW)
//  pc_target   out  AW  GOTO target = ir[8:0]
//  pc_lit      out  8   CALL target low byte = ir[7:0] (PC data_in)
//  w_load      out  1   RETLW: load W with w_lit
//  w_lit       out  8   ir[7:0]
//  stk_depth   out  2   current stack occupancy, 0..STACK_DEPTH
//  stk_ovf     out  1   sticky: push at full depth
//  stk_unf     out  1   sticky: pop at depth 0
// BEHAVIOUR
//  Reset (async):
//   - ir = 12'h000; ir_valid = 0; state = FILL.
//   - stk_depth = 0; stk_ovf = 0; stk_unf = 0.
//   - All strobes = 0.
//   - A mid-instruction reset discards the IR with no strobe.
//  Pipeline: in cycle n, ir = word at A and pc_addr = A+1. At the edge, the IR
//   latches rom_data (word at A+1), and the PC increments unless strobed.
//  FSM states:
//   - FILL: first cycle after reset. Outputs invalid, strobes 0; -> RUN.
//   - RUN: IR latched valid. Decode ir:
//       GOTO  ir[11:9]=3'b101   -> pc_load=1; -> FLUSH
//       CALL  ir[11:8]=4'b1001  -> pc_push=1; -> FLUSH
//       RETLW ir[11:8]=4'b1000  -> pc_pop=1, w_load=1; -> FLUSH
//       skip class (BTFSC 0110, BTFSS 0111, DECFSZ 0010_11, INCFSZ 0011_11)
//         with skip_cond=1      -> no strobe; -> FLUSH
//       pcl_wr=1 (any instruction) -> no strobe (datapath drives write_en); -> FLUSH
//       otherwise               -> stay RUN
//   - FLUSH: the IR latched this edge is squashed (ir=0, ir_valid=0). Strobes 0,
//     skip_cond and pcl_wr ignored; -> RUN.
//  Strobes and w_load are combinational from state+ir, asserted only when
//   ir_valid=1, at most one of load/push/pop per cycle.
//  pcl_wr takes priority over flow decode, matching the PC's write_en priority.
//  Stack accounting, updated on the same edge as the strobe:
//   - push: depth++ saturating at STACK_DEPTH; if already full, set stk_ovf.
//     The oldest entry is lost in the PC register.
//   - pop: depth-- saturating at 0; if already 0, set stk_unf.
//  Wrap: pc_addr 9'h1FF -> 9'h000 is handled by the PC; the sequencer is agnostic.
// STRUCTURE
//  - pic_isa_defs.vh (shared): opcode match/mask localparams, NOP encoding,
//    state encodings. Also used by the ALU decode.
//  - Sub-module pic_flow_decode: combinational ir -> {is_goto, is_call,
//    is_retlw, is_skip}.
//  - Top module holds the FSM, IR, and stack counter.
// TESTING (bench pairs this block with the PC register and a ROM model)
//  1 Release reset with ROM[0]=12'h0C5 -> cycle1 ir_valid=0; cycle2 ir=12'h0C5,
//    valid=1; pc_addr=1.
//  2 ROM[3]=GOTO 0x1A0 (12'hBA0) -> pc_load=1, pc_target=9'h1A0; next ir=NOP,
//    valid=0; then ir=ROM[0x1A0].
//  3 ROM[5]=CALL 0x40, ROM[0x40]=RETLW 0x55 -> push with pc_lit=8'h40, depth=1;
//    RETLW gives pop, w_lit=8'h55; returns to 6, depth=0.
//  4 BTFSS with skip_cond=1 at addr 8 -> ROM[9] squashed, ir=ROM[10] next;
//    with skip_cond=0 -> ROM[9] executes.
//  5 Three nested CALLs -> stk_depth saturates at 2, stk_ovf=1; three RETLWs ->
//    stk_unf=1 on the third.
//  6 pcl_wr asserted with MOVWF PCL -> next ir squashed; assert reset during
//    FLUSH -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pic_fetch_seq_pkg.sv
// Shared ISA constants and types for the PIC 12-bit fetch sequencer.
// These opcode patterns are also used by the ALU decode.
package pic_fetch_seq_pkg;

    localparam int PIC_AW          = 9;
    localparam int PIC_IW          = 12;
    localparam int PIC_STACK_DEPTH = 2;

    localparam logic [11:0] NOP = 12'h000;

    localparam logic [2:0] OP_GOTO   = 3'b101;
    localparam logic [3:0] OP_CALL   = 4'b1001;
    localparam logic [3:0] OP_RETLW  = 4'b1000;
    localparam logic [3:0] OP_BTFSC  = 4'b0110;
    localparam logic [3:0] OP_BTFSS  = 4'b0111;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic is_goto;
        logic is_call;
        logic is_retlw;
        logic is_skip;
    } flow_t;

endpackage

// File: rtl/pic_fetch_seq_if.sv
// Bus between the fetch sequencer (master) and the PC register / ROM / ALU side (slave).
interface pic_fetch_seq_if #(
    parameter int AW = 9,
    parameter int IW = 12
);
    logic [AW-1:0] pc_addr;
    logic [IW-1:0] rom_data;
    logic          skip_cond;
    logic          pcl_wr;
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic          pc_load;
    logic          pc_push;
    logic          pc_pop;
    logic [AW-1:0] pc_target;
    logic [7:0]    pc_lit;
    logic          w_load;
    logic [7:0]    w_lit;
    logic [1:0]    stk_depth;
    logic          stk_ovf;
    logic          stk_unf;

    modport master (
        input  pc_addr, rom_data, skip_cond, pcl_wr,
        output ir, ir_valid, pc_load, pc_push, pc_pop, pc_target, pc_lit,
               w_load, w_lit, stk_depth, stk_ovf, stk_unf
    );

    modport slave (
        output pc_addr, rom_data, skip_cond, pcl_wr,
        input  ir, ir_valid, pc_load, pc_push, pc_pop, pc_target, pc_lit,
               w_load, w_lit, stk_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pic_fetch_seq_decode.sv
// Change-of-flow classifier: sorts the executing instruction into
// GOTO / CALL / RETLW / conditional-skip classes. The classes are disjoint.
module pic_flow_decode
    import pic_fetch_seq_pkg::*;
(
    input  logic [PIC_IW-1:0] ir,
    output flow_t             flow
);

    // Opcode field matches; everything else is ordinary sequential flow
    always_comb begin
        flow          = '0;
        flow.is_goto  = (ir[11:9] == OP_GOTO);
        flow.is_call  = (ir[11:8] == OP_CALL);
        flow.is_retlw = (ir[11:8] == OP_RETLW);
        flow.is_skip  = (ir[11:8] == OP_BTFSC) || (ir[11:8] == OP_BTFSS) ||
                        (ir[11:6] == OP_DECFSZ) || (ir[11:6] == OP_INCFSZ);
    end

endmodule

// File: rtl/pic_fetch_seq.sv
// Instruction fetch / flow-control sequencer for the 12-bit PIC core.
// Holds the IR, the FILL/RUN/FLUSH pipeline FSM and the hardware-stack
// depth counter; drives the PC register's load/push/pop strobes.
module pic_fetch_seq
    import pic_fetch_seq_pkg::*;
#(
    parameter int AW          = PIC_AW,
    parameter int IW          = PIC_IW,
    parameter int STACK_DEPTH = PIC_STACK_DEPTH
) (
    input logic              clock,
    input logic              reset,
    pic_fetch_seq_if.master  bus
);

    localparam logic [1:0] STK_FULL = 2'(STACK_DEPTH);

    seq_state_e    state;
    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic [1:0]    depth_q;
    logic          ovf_q;
    logic          unf_q;
    flow_t         flow;
    logic          run;
    logic          do_load;
    logic          do_push;
    logic          do_pop;
    logic          redirect;

    pic_flow_decode u_decode (
        .ir   (ir_q),
        .flow (flow)
    );

    // Strobe generation; a PCL write wins over decoded flow because the PC
    // register gives its write_en priority over load/push/pop
    always_comb begin
        run      = (state == ST_RUN) && ir_valid_q;
        do_load  = run && !bus.pcl_wr && flow.is_goto;
        do_push  = run && !bus.pcl_wr && flow.is_call;
        do_pop   = run && !bus.pcl_wr && flow.is_retlw;
        redirect = run && (bus.pcl_wr || flow.is_goto || flow.is_call ||
                           flow.is_retlw || (flow.is_skip && bus.skip_cond));
    end

    // Pipeline FSM: after any change of flow the word fetched alongside it is squashed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_FILL;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_FILL, ST_FLUSH: begin
                    ir_q       <= bus.rom_data;
                    ir_valid_q <= 1'b1;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        ir_q       <= NOP;
                        ir_valid_q <= 1'b0;
                        state      <= ST_FLUSH;
                    end else begin
                        ir_q       <= bus.rom_data;
                        ir_valid_q <= 1'b1;
                    end
                end
                default: begin
                    ir_q       <= NOP;
                    ir_valid_q <= 1'b0;
                    state      <= ST_FILL;
                end
            endcase
        end
    end

    // Stack occupancy mirrors the PC register's stack; flags are sticky until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (do_push) begin
            if (depth_q == STK_FULL) ovf_q <= 1'b1;
            else                     depth_q <= depth_q + 2'd1;
        end else if (do_pop) begin
            if (depth_q == 2'd0) unf_q <= 1'b1;
            else                 depth_q <= depth_q - 2'd1;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc_load   = do_load;
    assign bus.pc_push   = do_push;
    assign bus.pc_pop    = do_pop;
    assign bus.pc_target = ir_q[AW-1:0];
    assign bus.pc_lit    = ir_q[7:0];
    assign bus.w_load    = do_pop;
    assign bus.w_lit     = ir_q[7:0];
    assign bus.stk_depth = depth_q;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_unf   = unf_q;

endmodule

// File: tb/tb_pic_fetch_seq.sv
// Bench for pic_fetch_seq: pairs the sequencer with a PC register and a ROM,
// and predicts the executed instruction stream at instruction level.
module tb_pic_fetch_seq;
    import pic_fetch_seq_pkg::*;

    localparam int K_PLAIN = 0;
    localparam int K_GOTO  = 1;
    localparam int K_CALL  = 2;
    localparam int K_RETLW = 3;
    localparam int K_SKIP  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rom [0:511];
    logic [8:0]  pc;
    logic [8:0]  stk0;
    logic [8:0]  stk1;
    logic [7:0]  pcl_data = 8'h00;
    int          checks = 0;
    int          errors = 0;

    bit          m_valid;
    logic [8:0]  m_addr;
    logic [8:0]  m_ret [$];
    int          m_depth;
    bit          m_ovf;
    bit          m_unf;

    logic [11:0] exp_ir;
    logic [8:0]  exp_pc_addr;
    bit          exp_valid, exp_load, exp_push, exp_pop, exp_ovf, exp_unf;
    int          exp_depth;

    always #5 clock = ~clock;

    pic_fetch_seq_if #(.AW(9), .IW(12)) bus ();

    pic_fetch_seq #(.AW(9), .IW(12), .STACK_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.pc_addr  = pc;
    assign bus.rom_data = rom[pc];

    // PC register: PCL write beats load, push, pop; otherwise increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc   <= 9'h000;
            stk0 <= 9'h000;
            stk1 <= 9'h000;
        end else if (bus.pcl_wr) begin
            pc <= {1'b0, pcl_data};
        end else if (bus.pc_load) begin
            pc <= bus.pc_target;
        end else if (bus.pc_push) begin
            stk1 <= stk0;
            stk0 <= pc;
            pc   <= {1'b0, bus.pc_lit};
        end else if (bus.pc_pop) begin
            pc   <= stk0;
            stk0 <= stk1;
        end else begin
            pc <= pc + 9'd1;
        end
    end

    function automatic int classify(input logic [11:0] w);
        int top3 = int'(w >> 9);
        int top4 = int'(w >> 8);
        int top6 = int'(w >> 6);
        if (top3 == 5) return K_GOTO;
        if (top4 == 9) return K_CALL;
        if (top4 == 8) return K_RETLW;
        if (top4 == 6 || top4 == 7 || top6 == 11 || top6 == 15) return K_SKIP;
        return K_PLAIN;
    endfunction

    task automatic clear_rom;
        for (int i = 0; i < 512; i++) rom[i] = 12'h000;
    endtask

    task automatic model_reset;
        m_valid = 1'b0;
        m_addr  = 9'h000;
        m_ret.delete();
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic apply_reset;
        reset         = 1'b1;
        bus.skip_cond = 1'b0;
        bus.pcl_wr    = 1'b0;
        pcl_data      = 8'h00;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    // One cycle: drive inputs after the falling edge, predict this cycle's
    // outputs, then advance the instruction-level model past the next edge
    task automatic drive(input bit skip, input bit pclw, input logic [7:0] pclv);
        int kind;
        @(negedge clock);
        bus.skip_cond = skip;
        bus.pcl_wr    = pclw;
        pcl_data      = pclv;
        #1;
        exp_valid   = m_valid;
        exp_ir      = m_valid ? rom[m_addr] : 12'h000;
        exp_pc_addr = m_valid ? m_addr + 9'd1 : m_addr;
        exp_load    = 1'b0;
        exp_push    = 1'b0;
        exp_pop     = 1'b0;
        exp_depth   = m_depth;
        exp_ovf     = m_ovf;
        exp_unf     = m_unf;
        if (!m_valid) begin
            m_valid = 1'b1;
        end else begin
            kind    = classify(exp_ir);
            m_valid = 1'b0;
            if (pclw) begin
                m_addr = {1'b0, pclv};
            end else if (kind == K_GOTO) begin
                exp_load = 1'b1;
                m_addr   = exp_ir[8:0];
            end else if (kind == K_CALL) begin
                exp_push = 1'b1;
                m_ret.push_front(m_addr + 9'd1);
                if (m_ret.size() > 2) void'(m_ret.pop_back());
                if (m_depth == 2) m_ovf = 1'b1;
                else              m_depth++;
                m_addr = {1'b0, exp_ir[7:0]};
            end else if (kind == K_RETLW) begin
                exp_pop = 1'b1;
                if (m_ret.size() != 0) m_addr = m_ret.pop_front();
                if (m_depth == 0) m_unf = 1'b1;
                else              m_depth--;
            end else if (kind == K_SKIP && skip) begin
                m_addr = m_addr + 9'd2;
            end else begin
                m_valid = 1'b1;
                m_addr  = m_addr + 9'd1;
            end
        end
    endtask

    task automatic test_reset;
        clear_rom();
        rom[0] = 12'h0C5;
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (bus.ir !== 12'h000) begin errors++; $display("[TB] FAIL reset_ir: got %h want 000", bus.ir); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.ir_valid); end
        checks++; if ({bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 0000", {bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load}); end
        checks++; if ({bus.stk_depth, bus.stk_ovf, bus.stk_unf} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_stack: got %b want 0000", {bus.stk_depth, bus.stk_ovf, bus.stk_unf}); end
        apply_reset();
        drive(0, 0, 8'h00);
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_valid: got %b want 0", bus.ir_valid); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'h0C5) begin errors++; $display("[TB] FAIL first_ir: got %h want 0c5", bus.ir); end
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b want 1", bus.ir_valid); end
        checks++; if (bus.pc_addr !== 9'h001) begin errors++; $display("[TB] FAIL first_pc: got %h want 001", bus.pc_addr); end
    endtask

    task automatic test_goto;
        clear_rom();
        rom[3] = 12'hBA0;
        rom[4] = 12'h123;
        rom[9'h1A0] = 12'hC77;
        apply_reset();
        repeat (4) drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("[TB] FAIL goto_load: got %b want 1", bus.pc_load); end
        checks++; if (bus.pc_target !== 9'h1A0) begin errors++; $display("[TB] FAIL goto_target: got %h want 1a0", bus.pc_target); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'h000 || bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL goto_squash: got ir=%h valid=%b want 000/0", bus.ir, bus.ir_valid); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'hC77 || bus.ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL goto_dest: got ir=%h valid=%b want c77/1", bus.ir, bus.ir_valid); end
        checks++; if (bus.pc_addr !== 9'h1A1) begin errors++; $display("[TB] FAIL goto_pc: got %h want 1a1", bus.pc_addr); end
    endtask

    task automatic test_call_return;
        clear_rom();
        rom[5] = 12'h940;
        rom[6] = 12'hC11;
        rom[9'h040] = 12'h855;
        apply_reset();
        repeat (6) drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        checks++; if (bus.pc_push !== 1'b1 || bus.pc_lit !== 8'h40) begin errors++; $display("[TB] FAIL call_push: got push=%b lit=%h want 1/40", bus.pc_push, bus.pc_lit); end
        drive(0, 0, 8'h00);
        checks++; if (bus.stk_depth !== 2'd1) begin errors++; $display("[TB] FAIL call_depth: got %0d want 1", bus.stk_depth); end
        drive(0, 0, 8'h00);
        checks++; if (bus.pc_pop !== 1'b1 || bus.w_load !== 1'b1 || bus.w_lit !== 8'h55) begin errors++; $display("[TB] FAIL retlw: got pop=%b wload=%b wlit=%h want 1/1/55", bus.pc_pop, bus.w_load, bus.w_lit); end
        drive(0, 0, 8'h00);
        checks++; if (bus.stk_depth !== 2'd0) begin errors++; $display("[TB] FAIL ret_depth: got %0d want 0", bus.stk_depth); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'hC11 || bus.pc_addr !== 9'h007) begin errors++; $display("[TB] FAIL ret_dest: got ir=%h pc=%h want c11/007", bus.ir, bus.pc_addr); end
    endtask

    task automatic test_skip;
        for (int pass = 0; pass < 2; pass++) begin
            clear_rom();
            rom[8]  = 12'h7E3;
            rom[9]  = 12'hC09;
            rom[10] = 12'hC0A;
            apply_reset();
            repeat (9) drive(0, 0, 8'h00);
            drive(pass == 0, 0, 8'h00);
            checks++; if ({bus.pc_load, bus.pc_push, bus.pc_pop} !== 3'b000) begin errors++; $display("[TB] FAIL skip_strobes: got %b want 000", {bus.pc_load, bus.pc_push, bus.pc_pop}); end
            drive(1, 0, 8'h00);
            if (pass == 0) begin
                checks++; if (bus.ir !== 12'h000 || bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL skip_squash: got ir=%h valid=%b want 000/0", bus.ir, bus.ir_valid); end
                drive(0, 0, 8'h00);
                checks++; if (bus.ir !== 12'hC0A || bus.pc_addr !== 9'd11) begin errors++; $display("[TB] FAIL skip_dest: got ir=%h pc=%h want c0a/00b", bus.ir, bus.pc_addr); end
            end else begin
                checks++; if (bus.ir !== 12'hC09 || bus.ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL noskip: got ir=%h valid=%b want c09/1", bus.ir, bus.ir_valid); end
            end
        end
    endtask

    task automatic test_stack_limits;
        clear_rom();
        rom[0]      = 12'h910;
        rom[9'h010] = 12'h920;
        rom[9'h020] = 12'h930;
        rom[9'h030] = 12'h801;
        rom[9'h021] = 12'h802;
        rom[9'h011] = 12'h803;
        apply_reset();
        repeat (5) drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        checks++; if (bus.pc_push !== 1'b1 || bus.stk_depth !== 2'd2 || bus.stk_ovf !== 1'b0) begin errors++; $display("[TB] FAIL third_call: got push=%b depth=%0d ovf=%b want 1/2/0", bus.pc_push, bus.stk_depth, bus.stk_ovf); end
        drive(0, 0, 8'h00);
        checks++; if (bus.stk_depth !== 2'd2 || bus.stk_ovf !== 1'b1) begin errors++; $display("[TB] FAIL overflow: got depth=%0d ovf=%b want 2/1", bus.stk_depth, bus.stk_ovf); end
        repeat (2) drive(0, 0, 8'h00);
        checks++; if (bus.stk_depth !== 2'd1) begin errors++; $display("[TB] FAIL pop1_depth: got %0d want 1", bus.stk_depth); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'h802 || bus.pc_pop !== 1'b1) begin errors++; $display("[TB] FAIL pop2: got ir=%h pop=%b want 802/1", bus.ir, bus.pc_pop); end
        repeat (2) drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'h803 || bus.stk_depth !== 2'd0 || bus.stk_unf !== 1'b0) begin errors++; $display("[TB] FAIL pop3: got ir=%h depth=%0d unf=%b want 803/0/0", bus.ir, bus.stk_depth, bus.stk_unf); end
        drive(0, 0, 8'h00);
        checks++; if (bus.stk_unf !== 1'b1 || bus.stk_depth !== 2'd0 || bus.stk_ovf !== 1'b1) begin errors++; $display("[TB] FAIL underflow: got unf=%b depth=%0d ovf=%b want 1/0/1", bus.stk_unf, bus.stk_depth, bus.stk_ovf); end
    endtask

    task automatic test_pcl_write_and_reset;
        clear_rom();
        rom[0]      = 12'h902;
        rom[2]      = 12'h022;
        rom[3]      = 12'hC03;
        rom[9'h050] = 12'hC50;
        apply_reset();
        repeat (3) drive(0, 0, 8'h00);
        drive(0, 1, 8'h50);
        checks++; if ({bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load} !== 4'b0000) begin errors++; $display("[TB] FAIL pclwr_strobes: got %b want 0000", {bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load}); end
        drive(0, 0, 8'h00);
        checks++; if (bus.ir_valid !== 1'b0 || bus.pc_addr !== 9'h050 || bus.stk_depth !== 2'd1) begin errors++; $display("[TB] FAIL pclwr_flush: got valid=%b pc=%h depth=%0d want 0/050/1", bus.ir_valid, bus.pc_addr, bus.stk_depth); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.ir !== 12'h000 || bus.ir_valid !== 1'b0 || bus.stk_depth !== 2'd0) begin errors++; $display("[TB] FAIL flush_reset: got ir=%h valid=%b depth=%0d want 000/0/0", bus.ir, bus.ir_valid, bus.stk_depth); end
        apply_reset();
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        checks++; if (bus.ir !== 12'h902 || bus.pc_push !== 1'b1) begin errors++; $display("[TB] FAIL after_reset: got ir=%h push=%b want 902/1", bus.ir, bus.pc_push); end
    endtask

    task automatic test_random;
        bit         skip, pclw;
        logic [7:0] pclv;
        for (int i = 0; i < 512; i++) rom[i] = 12'($urandom);
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            skip = 1'($urandom_range(1));
            pclv = 8'($urandom_range(255));
            pclw = m_valid && ($urandom_range(7) == 0 ||
                   (classify(rom[m_addr]) == K_RETLW && m_ret.size() == 0));
            drive(skip, pclw, pclv);
            checks++; if (bus.ir !== exp_ir) begin errors++; $display("[TB] FAIL rnd_ir cyc %0d: got %h want %h", cyc, bus.ir, exp_ir); end
            checks++; if (bus.ir_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d: got %b want %b", cyc, bus.ir_valid, exp_valid); end
            checks++; if (bus.pc_addr !== exp_pc_addr) begin errors++; $display("[TB] FAIL rnd_pc cyc %0d: got %h want %h", cyc, bus.pc_addr, exp_pc_addr); end
            checks++; if ({bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load} !== {exp_load, exp_push, exp_pop, exp_pop}) begin errors++; $display("[TB] FAIL rnd_strobes cyc %0d: got %b want %b", cyc, {bus.pc_load, bus.pc_push, bus.pc_pop, bus.w_load}, {exp_load, exp_push, exp_pop, exp_pop}); end
            checks++; if (bus.stk_depth !== 2'(exp_depth) || bus.stk_ovf !== exp_ovf || bus.stk_unf !== exp_unf) begin errors++; $display("[TB] FAIL rnd_stack cyc %0d: got %0d/%b/%b want %0d/%b/%b", cyc, bus.stk_depth, bus.stk_ovf, bus.stk_unf, exp_depth, exp_ovf, exp_unf); end
            if (exp_load) begin
                checks++; if (bus.pc_target !== exp_ir[8:0]) begin errors++; $display("[TB] FAIL rnd_target cyc %0d: got %h want %h", cyc, bus.pc_target, exp_ir[8:0]); end
            end
            if (exp_push) begin
                checks++; if (bus.pc_lit !== exp_ir[7:0]) begin errors++; $display("[TB] FAIL rnd_lit cyc %0d: got %h want %h", cyc, bus.pc_lit, exp_ir[7:0]); end
            end
            if (exp_pop) begin
                checks++; if (bus.w_lit !== exp_ir[7:0]) begin errors++; $display("[TB] FAIL rnd_wlit cyc %0d: got %h want %h", cyc, bus.w_lit, exp_ir[7:0]); end
            end
        end
    endtask

    initial begin
        bus.skip_cond = 1'b0;
        bus.pcl_wr    = 1'b0;
        model_reset();
        test_reset();
        test_goto();
        test_call_return();
        test_skip();
        test_stack_limits();
        test_pcl_write_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
